// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares the single SDRAM controller port among three requesters:
//   port 0 = CPU ROM/RAM, port 1 = CD-ROM DMA, port 2 = video/aux.
//   Each port uses a level request held until a one-cycle ACK pulse.
//   A grant registers the winning port's command, issues one read or
//   write strobe, waits for the controller to report done (or times out)
//   and then acknowledges the requester.
//
// Ports
//   SDRAM_CLK   sole clock
//   RESET       synchronous, active-high reset
//   REQ/WE      per-port request level and write select
//   ADDR/DIN/BE per-port address (25b), write data (16b), byte enables (2b)
//   ACK/ERR     one-hot completion pulse; ERR marks a timed-out access
//   DOUT        last read data, held until the next read completion
//   SDRAM_*     strobes and held command toward the SDRAM controller
//   SDRAM_RDY   controller idle/done, SDRAM_DOUT its read data
module sdram_arbiter #(
  parameter bit          PRIO0   = 1'b1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        SDRAM_CLK,
  input  logic        RESET,
  input  logic [2:0]  REQ,
  input  logic [2:0]  WE,
  input  logic [74:0] ADDR,
  input  logic [47:0] DIN,
  input  logic [5:0]  BE,
  output logic [2:0]  ACK,
  output logic        ERR,
  output logic [15:0] DOUT,
  output logic        SDRAM_RD,
  output logic        SDRAM_WR,
  output logic [24:0] SDRAM_ADDR,
  output logic [15:0] SDRAM_DIN,
  output logic [1:0]  SDRAM_BE,
  input  logic        SDRAM_RDY,
  input  logic [15:0] SDRAM_DOUT
);

  typedef enum logic [1:0] {ST_IDLE, ST_STRB, ST_HOLD, ST_WAIT} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state, state_next;
  logic [1:0]  gnt;
  logic        gnt_we;
  logic [1:0]  rr_ptr;
  logic [7:0]  cnt;
  logic [7:0]  cnt_inc;
  logic [2:0]  eligible;
  logic        found;
  logic [1:0]  grant_idx;
  logic        start_grant;
  logic        wait_done;
  logic        wait_timeout;
  logic        sel_we;
  logic [24:0] sel_addr;
  logic [15:0] sel_din;
  logic [1:0]  sel_be;

  // Arbitration. The port being acknowledged this cycle is masked so a
  // requester that keeps REQ high cannot win twice in a row.
  always_comb begin
    int c;
    eligible  = REQ & ~ACK;
    found     = 1'b0;
    grant_idx = 2'd0;
    c         = 0;
    if (PRIO0) begin
      if (eligible[0]) begin
        found     = 1'b1;
        grant_idx = 2'd0;
      end else if (rr_ptr == 2'd1) begin
        if (eligible[2]) begin
          found     = 1'b1;
          grant_idx = 2'd2;
        end else if (eligible[1]) begin
          found     = 1'b1;
          grant_idx = 2'd1;
        end
      end else begin
        if (eligible[1]) begin
          found     = 1'b1;
          grant_idx = 2'd1;
        end else if (eligible[2]) begin
          found     = 1'b1;
          grant_idx = 2'd2;
        end
      end
    end else begin
      // Search pointer+1, pointer+2, pointer+3 modulo 3
      for (int k = 1; k <= 3; k++) begin
        c = int'(rr_ptr) + k;
        if (c >= 3) c = c - 3;
        if (c >= 3) c = c - 3;
        if (!found && eligible[c[1:0]]) begin
          found     = 1'b1;
          grant_idx = c[1:0];
        end
      end
    end
  end

  // Command fields of the candidate port
  always_comb begin
    sel_we   = WE[0];
    sel_addr = ADDR[24:0];
    sel_din  = DIN[15:0];
    sel_be   = BE[1:0];
    case (grant_idx)
      2'd1: begin
        sel_we   = WE[1];
        sel_addr = ADDR[49:25];
        sel_din  = DIN[31:16];
        sel_be   = BE[3:2];
      end
      2'd2: begin
        sel_we   = WE[2];
        sel_addr = ADDR[74:50];
        sel_din  = DIN[47:32];
        sel_be   = BE[5:4];
      end
      default: ;
    endcase
  end

  // Next-state logic. HOLD exists because the controller only drops
  // SDRAM_RDY a cycle after the strobe; sampling it there would look done.
  always_comb begin
    state_next   = state;
    start_grant  = 1'b0;
    wait_done    = 1'b0;
    wait_timeout = 1'b0;
    cnt_inc      = cnt + 8'd1;
    case (state)
      ST_IDLE: begin
        if (SDRAM_RDY && found) begin
          start_grant = 1'b1;
          state_next  = ST_STRB;
        end
      end
      ST_STRB: state_next = ST_HOLD;
      ST_HOLD: state_next = ST_WAIT;
      ST_WAIT: begin
        if (SDRAM_RDY) begin
          wait_done  = 1'b1;
          state_next = ST_IDLE;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          wait_timeout = 1'b1;
          state_next   = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge SDRAM_CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Datapath: grant capture, strobes, timeout counter and completion.
  // Port 0 grants under PRIO0 leave the round-robin pointer alone so
  // ports 1 and 2 keep alternating between them.
  always_ff @(posedge SDRAM_CLK) begin
    if (RESET) begin
      ACK        <= 3'b000;
      ERR        <= 1'b0;
      DOUT       <= 16'h0000;
      SDRAM_RD   <= 1'b0;
      SDRAM_WR   <= 1'b0;
      SDRAM_ADDR <= 25'h0;
      SDRAM_DIN  <= 16'h0000;
      SDRAM_BE   <= 2'b00;
      gnt        <= 2'd0;
      gnt_we     <= 1'b0;
      cnt        <= 8'd0;
      rr_ptr     <= 2'd2;
    end else begin
      ACK      <= 3'b000;
      ERR      <= 1'b0;
      SDRAM_RD <= 1'b0;
      SDRAM_WR <= 1'b0;
      if (start_grant) begin
        gnt        <= grant_idx;
        gnt_we     <= sel_we;
        SDRAM_ADDR <= sel_addr;
        SDRAM_DIN  <= sel_din;
        SDRAM_BE   <= sel_be;
        SDRAM_RD   <= ~sel_we;
        SDRAM_WR   <= sel_we;
        if (!(PRIO0 && grant_idx == 2'd0)) rr_ptr <= grant_idx;
      end
      if (state == ST_HOLD) cnt <= 8'd0;
      if (state == ST_WAIT && !wait_done && !wait_timeout) cnt <= cnt_inc;
      if (wait_done) begin
        ACK <= 3'(3'b001 << gnt);
        if (!gnt_we) DOUT <= SDRAM_DOUT;
      end
      if (wait_timeout) begin
        ACK <= 3'(3'b001 << gnt);
        ERR <= 1'b1;
      end
    end
  end

endmodule
